// File: rtl/hl_adapter_pkg.sv
// hl_adapter_pkg: shared types and defaults for the hl_bus_adapter slice.
// Holds the adapter FSM state type and the default address width.
package hl_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HOLD,
        DONE
    } hl_state_t;

    localparam int HL_DEFAULT_ADDR_WIDTH = 32;

endpackage

// File: rtl/hl_edge_detect.sv
// hl_edge_detect: samples the slow clock level clk_l in the clk domain and
// produces a one-cycle rise pulse. With HL_ADAPTER_CLKL_SYNC_EN defined, a
// two-flop synchronizer sits in front of the edge-detect register, which
// delays every rise event by two cycles.
module hl_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic clk_l,
    output logic rise
);

    logic clk_l_q;
    logic clk_l_prev;

`ifdef HL_ADAPTER_CLKL_SYNC_EN
    logic sync_meta;
    logic sync_out;

    // Two-flop synchronizer for the asynchronous slow clock level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= clk_l;
            sync_out  <= sync_meta;
        end
    end

    // Edge-detect register fed from the synchronizer output
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_l_q <= 1'b0;
        end else begin
            clk_l_q <= sync_out;
        end
    end
`else
    // Edge-detect register sampling clk_l directly
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_l_q <= 1'b0;
        end else begin
            clk_l_q <= clk_l;
        end
    end
`endif

    // Previous sampled level, so a low-to-high step is visible for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_l_prev <= 1'b0;
        end else begin
            clk_l_prev <= clk_l_q;
        end
    end

    assign rise = clk_l_q & ~clk_l_prev;

endmodule

// File: rtl/hl_bus_adapter.sv
// hl_bus_adapter: single-transaction bridge from a fast bus master to a slow
// clk_l-paced memory/flash port. A request is latched in IDLE, presented on
// the slow side for a full clk_l period (two rise events), then read data is
// returned with a four-phase ready handshake. Define HL_ADAPTER_CLKL_SYNC_EN
// to put a two-flop synchronizer on clk_l (see hl_edge_detect).
module hl_bus_adapter
    import hl_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = HL_DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_l,
    input  logic                  h_read_en,
    input  logic                  h_write_en,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_data_in,
    output logic                  h_data_ready,
    output logic [DATA_WIDTH-1:0] h_data_out,
    output logic                  l_read_en,
    output logic                  l_write_en,
    output logic [ADDR_WIDTH-1:0] l_addr,
    output logic [DATA_WIDTH-1:0] l_data_in,
    input  logic [DATA_WIDTH-1:0] l_data_out
);

    hl_state_t             state;
    hl_state_t             state_next;
    logic                  rise;
    logic                  h_data_ready_next;
    logic [DATA_WIDTH-1:0] h_data_out_next;
    logic                  l_read_en_next;
    logic                  l_write_en_next;
    logic [ADDR_WIDTH-1:0] l_addr_next;
    logic [DATA_WIDTH-1:0] l_data_in_next;

    hl_edge_detect u_edge (
        .clk   (clk),
        .rst   (rst),
        .clk_l (clk_l),
        .rise  (rise)
    );

    // Next state and next registered outputs; everything holds by default
    always_comb begin
        state_next        = state;
        h_data_ready_next = h_data_ready;
        h_data_out_next   = h_data_out;
        l_read_en_next    = l_read_en;
        l_write_en_next   = l_write_en;
        l_addr_next       = l_addr;
        l_data_in_next    = l_data_in;
        case (state)
            IDLE: begin
                if (h_write_en) begin
                    l_addr_next     = h_addr;
                    l_data_in_next  = h_data_in;
                    l_write_en_next = 1'b1;
                    state_next      = ARM;
                end else if (h_read_en) begin
                    l_addr_next    = h_addr;
                    l_read_en_next = 1'b1;
                    state_next     = ARM;
                end
            end
            ARM: begin
                if (rise) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (rise) begin
                    if (l_read_en) begin
                        h_data_out_next = l_data_out;
                    end
                    l_read_en_next    = 1'b0;
                    l_write_en_next   = 1'b0;
                    h_data_ready_next = 1'b1;
                    state_next        = DONE;
                end
            end
            DONE: begin
                if (!h_read_en && !h_write_en) begin
                    h_data_ready_next = 1'b0;
                    state_next        = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            h_data_ready <= 1'b0;
            h_data_out   <= '0;
            l_read_en    <= 1'b0;
            l_write_en   <= 1'b0;
            l_addr       <= '0;
            l_data_in    <= '0;
        end else begin
            state        <= state_next;
            h_data_ready <= h_data_ready_next;
            h_data_out   <= h_data_out_next;
            l_read_en    <= l_read_en_next;
            l_write_en   <= l_write_en_next;
            l_addr       <= l_addr_next;
            l_data_in    <= l_data_in_next;
        end
    end

endmodule

// File: tb/tb_hl_bus_adapter.sv
// tb_hl_bus_adapter: randomized, self-checking bench for hl_bus_adapter with
// a transaction-level reference model and directed literal checks.
`timescale 1ns/1ps
module tb_hl_bus_adapter;

    localparam int DW = 32;
    localparam int AW = 32;
`ifdef HL_ADAPTER_CLKL_SYNC_EN
    localparam int SYNC_LAT = 3;
`else
    localparam int SYNC_LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_l = 1'b1;
    logic          h_read_en = 1'b0;
    logic          h_write_en = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_data_in = '0;
    logic          h_data_ready;
    logic [DW-1:0] h_data_out;
    logic          l_read_en;
    logic          l_write_en;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_data_in;
    logic [DW-1:0] l_data_out;

    logic [DW-1:0] dev_fixed = '0;
    logic [DW-1:0] dev_rand = '0;
    logic          random_device = 1'b0;
    int            clk_l_cnt = 0;

    int check_count = 0;
    int pass_count = 0;

    hl_bus_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_l        (clk_l),
        .h_read_en    (h_read_en),
        .h_write_en   (h_write_en),
        .h_addr       (h_addr),
        .h_data_in    (h_data_in),
        .h_data_ready (h_data_ready),
        .h_data_out   (h_data_out),
        .l_read_en    (l_read_en),
        .l_write_en   (l_write_en),
        .l_addr       (l_addr),
        .l_data_in    (l_data_in),
        .l_data_out   (l_data_out)
    );

    always #5 clk = ~clk;

    // Slow clock: 8 clk periods, 4 high and 4 low; random device data source
    always @(negedge clk) begin
        clk_l_cnt = (clk_l_cnt + 1) % 8;
        clk_l     = (clk_l_cnt < 4);
        dev_rand  = $urandom;
    end

    assign l_data_out = random_device ? dev_rand : dev_fixed;

    // ------------------------------------------------------------------
    // Reference model: a transaction counts down two clk_l rise events
    // ------------------------------------------------------------------
    logic          model_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic          m_rd = 1'b0;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_active = 1'b0;
    int            m_rises_left = 0;
    logic          m_hist [SYNC_LAT];
    logic          m_prev = 1'b0;
    logic          m_rise_seen;

    always @(posedge clk) begin
        if (rst) begin
            model_valid = 1'b1;
            m_ready  = 1'b0;
            m_rd     = 1'b0;
            m_wr     = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
            m_rdata  = '0;
            m_active = 1'b0;
            m_rises_left = 0;
            m_prev   = 1'b0;
            for (int i = 0; i < SYNC_LAT; i++) m_hist[i] = 1'b0;
        end else begin
            m_rise_seen = m_hist[SYNC_LAT-1] && !m_prev;
            if (m_ready) begin
                if (!h_read_en && !h_write_en) m_ready = 1'b0;
            end else if (m_active) begin
                if (m_rise_seen) begin
                    m_rises_left = m_rises_left - 1;
                    if (m_rises_left == 0) begin
                        if (m_rd) m_rdata = l_data_out;
                        m_rd     = 1'b0;
                        m_wr     = 1'b0;
                        m_ready  = 1'b1;
                        m_active = 1'b0;
                    end
                end
            end else if (h_write_en) begin
                m_addr  = h_addr;
                m_wdata = h_data_in;
                m_wr    = 1'b1;
                m_active = 1'b1;
                m_rises_left = 2;
            end else if (h_read_en) begin
                m_addr  = h_addr;
                m_rd    = 1'b1;
                m_active = 1'b1;
                m_rises_left = 2;
            end
            m_prev = m_hist[SYNC_LAT-1];
            for (int i = SYNC_LAT - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = clk_l;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("model_h_data_ready", h_data_ready, m_ready);
            checkOutput("model_h_data_out",   h_data_out,   m_rdata);
            checkOutput("model_l_read_en",    l_read_en,    m_rd);
            checkOutput("model_l_write_en",   l_write_en,   m_wr);
            checkOutput("model_l_addr",       l_addr,       m_addr);
            checkOutput("model_l_data_in",    l_data_in,    m_wdata);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called right after a negedge)
    // ------------------------------------------------------------------
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] data);
        h_read_en  = rd;
        h_write_en = wr;
        h_addr     = addr;
        h_data_in  = data;
    endtask

    task automatic waitReady(input int max_cycles, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (h_data_ready) seen = 1'b1;
        end
        checkOutput(name, seen, 1);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_ready"},  h_data_ready, 0);
        checkOutput({name, "_dout"},   h_data_out,   0);
        checkOutput({name, "_rd"},     l_read_en,    0);
        checkOutput({name, "_wr"},     l_write_en,   0);
        checkOutput({name, "_addr"},   l_addr,       0);
        checkOutput({name, "_din"},    l_data_in,    0);
    endtask

    initial begin
        bit reached;
        int kind;

        // Reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("reset");

        // Read 0x100 returning 0xA5
        dev_fixed = 32'h0000_00A5;
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        checkOutput("read_l_read_en", l_read_en, 1);
        checkOutput("read_l_addr", l_addr, 32'h100);
        waitReady(40, "read_ready_timeout");
        checkOutput("read_h_data_out", h_data_out, 32'hA5);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("read_ready_drop", h_data_ready, 0);

        // Write 0x2000_0004 <- 0xDEAD_BEEF
        applyStimulus(1'b0, 1'b1, 32'h2000_0004, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("write_l_write_en", l_write_en, 1);
        checkOutput("write_l_data_in", l_data_in, 32'hDEAD_BEEF);
        checkOutput("write_l_addr", l_addr, 32'h2000_0004);
        h_addr    = 32'h1234_5678;
        h_data_in = 32'h0BAD_F00D;
        waitReady(40, "write_ready_timeout");
        checkOutput("write_l_data_in_held", l_data_in, 32'hDEAD_BEEF);
        checkOutput("write_h_data_out_kept", h_data_out, 32'hA5);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Simultaneous request: write wins
        applyStimulus(1'b1, 1'b1, 32'h44, 32'h0000_0077);
        @(negedge clk);
        checkOutput("both_l_write_en", l_write_en, 1);
        checkOutput("both_l_read_en", l_read_en, 0);
        waitReady(40, "both_ready_timeout");
        checkOutput("both_h_data_out_kept", h_data_out, 32'hA5);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Reset while in HOLD
        dev_fixed = 32'h0000_00EE;
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h0);
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            @(negedge clk);
            if (m_active && m_rises_left == 1) reached = 1'b1;
        end
        checkOutput("reached_hold", reached, 1);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("midreset");
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("midreset_no_ready", h_data_ready, 0);
        dev_fixed = 32'h0000_005A;
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h0);
        waitReady(40, "after_reset_ready_timeout");
        checkOutput("after_reset_h_data_out", h_data_out, 32'h5A);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Back-to-back reads 0x10 then 0x14
        dev_fixed = 32'h0000_0011;
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
        waitReady(40, "b2b_first_timeout");
        checkOutput("b2b_first_data", h_data_out, 32'h11);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("b2b_ready_low", h_data_ready, 0);
        dev_fixed = 32'h0000_0022;
        applyStimulus(1'b1, 1'b0, 32'h14, 32'h0);
        @(negedge clk);
        checkOutput("b2b_second_start", l_read_en, 1);
        checkOutput("b2b_second_addr", l_addr, 32'h14);
        waitReady(40, "b2b_second_timeout");
        checkOutput("b2b_second_data", h_data_out, 32'h22);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Randomized transactions, model checks every cycle
        random_device = 1'b1;
        for (int t = 0; t < 80; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            kind = $urandom_range(0, 2);
            applyStimulus(kind != 1, kind != 0, $urandom, $urandom);
            @(negedge clk);
            h_addr    = $urandom;
            h_data_in = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, 12)) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
                @(negedge clk);
            end else begin
                waitReady(40, "rand_ready_timeout");
                repeat ($urandom_range(0, 2)) @(negedge clk);
                applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/hl_bus_adapter.md
# hl_bus_adapter

Single-transaction bridge between a fast-clocked bus master and a slow external memory or flash port. The master runs on `clk`. The slow side is paced by `clk_l`, a slow clock that arrives as an ordinary input and is sampled in the `clk` domain. The SoC top instantiates one copy per external device: 8-bit data for flash, 32-bit data for RAM. Each copy holds a master request stable on the slow side for a full `clk_l` period, then returns the read data with a ready handshake.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of the data path.
- `ADDR_WIDTH`, default 32: width of the address path.

Ports:
- `clk` in 1: the only clock; the master (fast) clock.
- `rst` in 1: synchronous, active-high reset.
- `clk_l` in 1: slow clock level. Treated as data and sampled on `clk`.
- `h_read_en` in 1: master read request. Held high until the handshake completes.
- `h_write_en` in 1: master write request. Held high until the handshake completes.
- `h_addr` in ADDR_WIDTH: master address.
- `h_data_in` in DATA_WIDTH: master write data.
- `h_data_ready` out 1: transaction complete, `h_data_out` valid.
- `h_data_out` out DATA_WIDTH: read data returned to the master.
- `l_read_en` out 1: slow-side read strobe.
- `l_write_en` out 1: slow-side write strobe.
- `l_addr` out ADDR_WIDTH: slow-side address.
- `l_data_in` out DATA_WIDTH: slow-side write data (driven by the adapter).
- `l_data_out` in DATA_WIDTH: slow-side read data (driven by the device).

## Operation
- **Edge detect:** `clk_l` is registered as `clk_l_q`. A rise event is `clk_l_q & ~clk_l_prev`, and lasts one cycle.
- **IDLE:**
  - If `h_write_en` is high, latch `h_addr` and `h_data_in`, set `l_write_en` = 1, go to ARM.
  - Else if `h_read_en` is high, latch `h_addr`, set `l_read_en` = 1, go to ARM.
  - If both requests are high, the write wins and `l_read_en` stays 0.
- **ARM:** wait for the first rise event, then go to HOLD. The slow side samples the request on this `clk_l` edge.
- **HOLD:** wait for the next rise event. On that event:
  - capture `l_data_out` into `h_data_out` (reads only; writes leave `h_data_out` unchanged);
  - clear `l_read_en` and `l_write_en`;
  - go to DONE.
- **DONE:** `h_data_ready` = 1. It stays high until `h_read_en` and `h_write_en` are both low, then the FSM returns to IDLE. This is a four-phase handshake.
- **Stable outputs:** `l_addr` and `l_data_in` hold the latched values from IDLE until the next transaction. They do not follow `h_*` mid-transaction.
- **Reset:** `rst` high in any state gives IDLE on the next edge, with every output at 0, including `h_data_out`, `l_addr` and `l_data_in`. An in-flight transaction is abandoned and no ready pulse is issued.

## Timing
- Reset values: all outputs 0. The edge-detect registers reset to 0, so if `clk_l` is already high after reset, that counts as a rise.
- Request to `l_*_en` high: 1 `clk` cycle. All outputs are registered.
- Request to `h_data_ready`: 1 cycle, plus the wait for two `clk_l` rises, plus 1 cycle (plus sync latency if the macro is set).
- The write to `h_data_out` and the assertion of `h_data_ready` happen on the same clock edge.
- `clk_l` high and low phases must each last at least 2 `clk` periods (3 with the synchronizer). Shorter pulses may be missed, and behaviour is then undefined.
- Minimum gap between transactions: 1 IDLE cycle after the requests drop.

## Configuration
- `HL_ADAPTER_CLKL_SYNC_EN` defined: `clk_l` passes through a 2-flop synchronizer before the edge-detect register. Rise events appear 2 cycles later.
- Not defined: a single register feeds the edge detect.
- Functional behaviour is otherwise identical.

## Structure
- Package `hl_adapter_pkg`:
  - FSM state typedef {IDLE, ARM, HOLD, DONE};
  - default `ADDR_WIDTH` constant (32).
- One sub-module, `hl_edge_detect`: optional synchronizer, previous-value register, one-cycle `rise` output.

## Test plan
Common setup: `clk_l` period 8 `clk` cycles (4 high, 4 low), macro undefined, `DATA_WIDTH`=8 unless stated.
- **Reset:** `rst`=1 for 2 cycles, then release → every output reads 0; FSM in IDLE.
- **Read:** `h_read_en`=1, `h_addr`=0x100, device drives `l_data_out`=0xA5 → `l_read_en`=1 and `l_addr`=0x100 after 1 cycle. After the second `clk_l` rise, `h_data_ready`=1 and `h_data_out`=0xA5. Ready drops 1 cycle after `h_read_en` drops.
- **Write (`DATA_WIDTH`=32):** `h_write_en`=1, `h_addr`=0x2000_0004, `h_data_in`=0xDEAD_BEEF → `l_write_en`=1 with `l_data_in`=0xDEAD_BEEF held for one full `clk_l` period. Then `h_data_ready`=1 and `h_data_out` is unchanged.
- **Simultaneous request:** `h_read_en`=`h_write_en`=1 → only `l_write_en` asserts; `l_read_en` stays 0 throughout.
- **Reset mid-transaction:** `rst`=1 while in HOLD → next cycle all outputs 0 and no `h_data_ready`. A new read after release completes normally.
- **Back-to-back reads:** two reads, 0x10 then 0x14 → the second starts only after `h_data_ready` drops. Each returns its own device data; `l_addr` never changes mid-transaction.
